// File: rtl/core_ma_pkg.sv
// core_ma_pkg: shared types and constants for the memory-access stage
package core_ma_pkg;
   typedef enum logic [1:0] {MA_BYTE = 2'd0, MA_HALF = 2'd1, MA_WORD = 2'd2} ma_size_e;
   typedef enum logic {MA_IDLE, MA_WAIT} ma_state_e;
   localparam logic [31:0] MA_CAUSE_LD_MISALIGN = 32'd4;
   localparam logic [31:0] MA_CAUSE_ST_MISALIGN = 32'd6;
   function automatic ma_size_e to_size(input logic [1:0] op);
      return op == 2'd3 ? MA_WORD : ma_size_e'(op);
   endfunction
endpackage

// File: rtl/core_ma_align.sv
// core_ma_align: byte-lane formatting for stores, extraction/extension for loads, alignment check
module core_ma_align
   import core_ma_pkg::*;
(
   input  logic [1:0]  op_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_byte_en,
   output logic        misalign,
   input  ma_size_e    ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_sign,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);
   ma_size_e    st_size;
   logic [31:0] sh;
   // replicate store data across lanes, pick enables, and extend the shifted load word
   always_comb begin
      st_size    = to_size(op_type);
      st_wdata   = st_size == MA_BYTE ? {4{st_data[7:0]}} : st_size == MA_HALF ? {2{st_data[15:0]}} : st_data;
      st_byte_en = st_size == MA_BYTE ? 4'b0001 << addr_lo : st_size == MA_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      misalign   = st_size == MA_HALF ? addr_lo[0] : st_size == MA_WORD ? |addr_lo : 1'b0;
      sh         = ld_rdata >> {ld_off, 3'b000};
      ld_result  = ld_size == MA_BYTE ? {{24{ld_sign & sh[7]}}, sh[7:0]} :
                   ld_size == MA_HALF ? {{16{ld_sign & sh[15]}}, sh[15:0]} : sh;
   end
endmodule

// File: rtl/core_ma.sv
// core_ma: memory-access pipeline stage between EX/MEM and MA/WB
module core_ma
   import core_ma_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              em_valid,
   output logic              em_ready,
   input  logic [DATA_W-1:0] em_reg_data_mem_addr,
   input  logic [DATA_W-1:0] em_csr_data_mem_data,
   input  logic              em_mem_read,
   input  logic              em_mem_write,
   input  logic [1:0]        em_mem_op_type,
   input  logic              em_mem_sign,
   input  logic [4:0]        em_rd,
   input  logic              em_reg_write,
   input  logic [11:0]       em_csr,
   input  logic              em_csr_write,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_write,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_byte_en,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_rvalid,
   output logic              mw_valid,
   output logic [4:0]        mw_rd,
   output logic              mw_reg_write,
   output logic [DATA_W-1:0] mw_reg_write_data,
   output logic              mw_mem_data_valid,
   output logic [11:0]       mw_csr,
   output logic              mw_csr_write,
   output logic [DATA_W-1:0] mw_csr_data,
   output logic              ma_misalign,
   output logic [31:0]       ma_cause,
   output logic [31:0]       ma_badaddr
);
   ma_state_e   state, state_n;
   ma_size_e    ld_size;
   logic [1:0]  ld_off;
   logic        ld_sign, misalign, is_mem, idle;
   logic [31:0] ld_result;

   core_ma_align u_align (
      .op_type    (em_mem_op_type),
      .addr_lo    (em_reg_data_mem_addr[1:0]),
      .st_data    (em_csr_data_mem_data),
      .st_wdata   (bus_wdata),
      .st_byte_en (bus_byte_en),
      .misalign   (misalign),
      .ld_size    (ld_size),
      .ld_off     (ld_off),
      .ld_sign    (ld_sign),
      .ld_rdata   (bus_rdata),
      .ld_result  (ld_result)
   );

   // handshake, bus request and next-state decode
   always_comb begin
      is_mem    = em_mem_read | em_mem_write;
      idle      = state == MA_IDLE && !rest;
      bus_valid = idle & em_valid & is_mem & !misalign;
      em_ready  = idle & em_valid & (!is_mem | misalign | bus_ready);
      bus_write = em_mem_write;
      bus_addr  = {em_reg_data_mem_addr[ADDR_W-1:2], 2'b00};
      state_n   = state == MA_IDLE ? (bus_valid && bus_ready && !em_mem_write ? MA_WAIT : MA_IDLE)
                                   : (bus_rvalid ? MA_IDLE : MA_WAIT);
   end

   // state register
   always_ff @(posedge clk) begin
      if (rest) state <= MA_IDLE;
      else      state <= state_n;
   end

   // MA/WB register, latched load format and misalignment report
   always_ff @(posedge clk) begin
      if (rest) begin
         mw_valid          <= 1'b0;
         mw_rd             <= '0;
         mw_reg_write      <= 1'b0;
         mw_reg_write_data <= '0;
         mw_mem_data_valid <= 1'b1;
         mw_csr            <= '0;
         mw_csr_write      <= 1'b0;
         mw_csr_data       <= '0;
         ma_misalign       <= 1'b0;
         ma_cause          <= '0;
         ma_badaddr        <= '0;
         ld_size           <= MA_WORD;
         ld_off            <= '0;
         ld_sign           <= 1'b0;
      end else if (state == MA_IDLE) begin
         ma_misalign  <= 1'b0;
         mw_valid     <= 1'b0;
         mw_reg_write <= 1'b0;
         mw_csr_write <= 1'b0;
         if (em_ready && !is_mem) begin
            mw_valid          <= 1'b1;
            mw_rd             <= em_rd;
            mw_reg_write      <= em_reg_write;
            mw_reg_write_data <= em_reg_data_mem_addr;
            mw_mem_data_valid <= 1'b1;
            mw_csr            <= em_csr;
            mw_csr_write      <= em_csr_write;
            mw_csr_data       <= em_csr_data_mem_data;
         end else if (em_ready && misalign) begin
            ma_misalign <= 1'b1;
            ma_cause    <= em_mem_write ? MA_CAUSE_ST_MISALIGN : MA_CAUSE_LD_MISALIGN;
            ma_badaddr  <= em_reg_data_mem_addr;
         end else if (em_ready && em_mem_write) begin
            mw_valid <= 1'b1;
         end else if (em_ready) begin
            ld_off            <= em_reg_data_mem_addr[1:0];
            ld_size           <= to_size(em_mem_op_type);
            ld_sign           <= em_mem_sign;
            mw_rd             <= em_rd;
            mw_reg_write      <= em_reg_write;
            mw_mem_data_valid <= 1'b0;
         end
      end else if (bus_rvalid) begin
         mw_reg_write_data <= ld_result;
         mw_mem_data_valid <= 1'b1;
         mw_valid          <= 1'b1;
      end
   end
endmodule

// File: tb/tb_core_ma.sv
// tb_core_ma: directed table-driven and sequence checks for the memory-access stage
module tb_core_ma;
   logic        clk = 0, rest = 1;
   logic        em_valid = 0, em_ready;
   logic [31:0] em_reg_data_mem_addr = 0, em_csr_data_mem_data = 0;
   logic        em_mem_read = 0, em_mem_write = 0, em_mem_sign = 0;
   logic [1:0]  em_mem_op_type = 0;
   logic [4:0]  em_rd = 0;
   logic        em_reg_write = 0, em_csr_write = 0;
   logic [11:0] em_csr = 0;
   logic        bus_valid, bus_ready = 0, bus_write, bus_rvalid = 0;
   logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
   logic [3:0]  bus_byte_en;
   logic        mw_valid, mw_reg_write, mw_mem_data_valid, mw_csr_write, ma_misalign;
   logic [4:0]  mw_rd;
   logic [11:0] mw_csr;
   logic [31:0] mw_reg_write_data, mw_csr_data, ma_cause, ma_badaddr;
   int          n_checks = 0, n_fail = 0;

   core_ma dut (
      .clk(clk), .rest(rest), .em_valid(em_valid), .em_ready(em_ready),
      .em_reg_data_mem_addr(em_reg_data_mem_addr), .em_csr_data_mem_data(em_csr_data_mem_data),
      .em_mem_read(em_mem_read), .em_mem_write(em_mem_write), .em_mem_op_type(em_mem_op_type),
      .em_mem_sign(em_mem_sign), .em_rd(em_rd), .em_reg_write(em_reg_write), .em_csr(em_csr),
      .em_csr_write(em_csr_write), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata),
      .bus_rvalid(bus_rvalid), .mw_valid(mw_valid), .mw_rd(mw_rd), .mw_reg_write(mw_reg_write),
      .mw_reg_write_data(mw_reg_write_data), .mw_mem_data_valid(mw_mem_data_valid), .mw_csr(mw_csr),
      .mw_csr_write(mw_csr_write), .mw_csr_data(mw_csr_data), .ma_misalign(ma_misalign),
      .ma_cause(ma_cause), .ma_badaddr(ma_badaddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        valid, rd_, wr;
      logic [1:0]  op;
      logic [31:0] addr, data;
      logic        br;
      logic        x_ready, x_bv;
      logic [31:0] x_baddr, x_wdata;
      logic [3:0]  x_be;
      logic        x_mvalid, x_regw, x_mis;
      logic [31:0] x_cause;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic w, input logic [1:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] d);
      em_valid = v; em_mem_read = r; em_mem_write = w; em_mem_op_type = op; em_mem_sign = s;
      em_reg_data_mem_addr = a; em_csr_data_mem_data = d;
      em_rd = 5'd5; em_reg_write = 1; em_csr = 12'h300; em_csr_write = 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{"alu",       1,0,0,2'd0,32'h1234,    32'hCAFE,    1, 1,0,32'h0,     32'h0,        4'h0, 1,1,0,32'h0};
      vecs[1] = '{"st_word",   1,0,1,2'd2,32'h100,     32'hDEADBEEF,1, 1,1,32'h100,   32'hDEADBEEF, 4'hF, 1,0,0,32'h0};
      vecs[2] = '{"st_half",   1,0,1,2'd1,32'h106,     32'h12345678,1, 1,1,32'h104,   32'h56785678, 4'hC, 1,0,0,32'h0};
      vecs[3] = '{"st_byte",   1,0,1,2'd0,32'h201,     32'h55,      1, 1,1,32'h200,   32'h55555555, 4'h2, 1,0,0,32'h0};
      vecs[4] = '{"st_resv",   1,0,1,2'd3,32'h300,     32'h11223344,1, 1,1,32'h300,   32'h11223344, 4'hF, 1,0,0,32'h0};
      vecs[5] = '{"mis_st_h",  1,0,1,2'd1,32'h401,     32'h0,       1, 1,0,32'h0,     32'h0,        4'h0, 0,0,1,32'd6};
      vecs[6] = '{"mis_ld_w",  1,1,0,2'd2,32'h3002,    32'h0,       1, 1,0,32'h0,     32'h0,        4'h0, 0,0,1,32'd4};
      vecs[7] = '{"mis_st_w",  1,0,1,2'd2,32'h502,     32'h0,       0, 1,0,32'h0,     32'h0,        4'h0, 0,0,1,32'd6};
      vecs[8] = '{"st_noready",1,0,1,2'd2,32'h600,     32'h77,      0, 0,1,32'h600,   32'h77,       4'hF, 0,0,0,32'h0};
      vecs[9] = '{"no_entry",  0,1,0,2'd2,32'h700,     32'h0,       1, 0,0,32'h0,     32'h0,        4'h0, 0,0,0,32'h0};

      // reset behaviour: combinational outputs gated while rest is high
      drive(1, 0, 1, 2'd2, 0, 32'h100, 32'h1); bus_ready = 1;
      step(); step();
      chk("rst_em_ready", {31'b0, em_ready}, 0);
      chk("rst_bus_valid", {31'b0, bus_valid}, 0);
      chk("rst_mw_valid", {31'b0, mw_valid}, 0);
      chk("rst_mdv", {31'b0, mw_mem_data_valid}, 1);
      chk("rst_misalign", {31'b0, ma_misalign}, 0);
      chk("rst_cause", ma_cause, 0);
      drive(0, 0, 0, 2'd0, 0, 0, 0); rest = 0;
      step();

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].valid, vecs[i].rd_, vecs[i].wr, vecs[i].op, 0, vecs[i].addr, vecs[i].data);
         bus_ready = vecs[i].br;
         #1;
         chk({vecs[i].name, "_em_ready"}, {31'b0, em_ready}, {31'b0, vecs[i].x_ready});
         chk({vecs[i].name, "_bus_valid"}, {31'b0, bus_valid}, {31'b0, vecs[i].x_bv});
         if (vecs[i].x_bv) begin
            chk({vecs[i].name, "_bus_write"}, {31'b0, bus_write}, {31'b0, vecs[i].wr});
            chk({vecs[i].name, "_bus_addr"}, bus_addr, vecs[i].x_baddr);
            chk({vecs[i].name, "_wdata"}, bus_wdata, vecs[i].x_wdata);
            chk({vecs[i].name, "_be"}, {28'b0, bus_byte_en}, {28'b0, vecs[i].x_be});
         end
         step();
         drive(0, 0, 0, 2'd0, 0, 0, 0); bus_ready = 0;
         chk({vecs[i].name, "_mw_valid"}, {31'b0, mw_valid}, {31'b0, vecs[i].x_mvalid});
         chk({vecs[i].name, "_mw_reg_write"}, {31'b0, mw_reg_write}, {31'b0, vecs[i].x_regw});
         chk({vecs[i].name, "_mw_csr_write"}, {31'b0, mw_csr_write}, {31'b0, vecs[i].x_regw});
         chk({vecs[i].name, "_misalign"}, {31'b0, ma_misalign}, {31'b0, vecs[i].x_mis});
         if (vecs[i].x_mis) begin
            chk({vecs[i].name, "_cause"}, ma_cause, vecs[i].x_cause);
            chk({vecs[i].name, "_badaddr"}, ma_badaddr, vecs[i].addr);
         end
         if (vecs[i].x_regw) begin
            chk({vecs[i].name, "_mw_rd"}, {27'b0, mw_rd}, 32'd5);
            chk({vecs[i].name, "_mw_data"}, mw_reg_write_data, vecs[i].addr);
            chk({vecs[i].name, "_mw_csr_data"}, mw_csr_data, vecs[i].data);
            chk({vecs[i].name, "_mw_csr"}, {20'b0, mw_csr}, 32'h300);
         end
         step();
         chk({vecs[i].name, "_bubble"}, {31'b0, mw_valid}, 0);
      end

      // store byte held stable until bus_ready arrives
      drive(1, 0, 1, 2'd0, 0, 32'h1003, 32'hAB);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stb_hold_bv", {31'b0, bus_valid}, 1);
         chk("stb_hold_addr", bus_addr, 32'h1000);
         chk("stb_hold_be", {28'b0, bus_byte_en}, 32'h8);
         chk("stb_hold_wdata", bus_wdata, 32'hABABABAB);
         chk("stb_hold_ready", {31'b0, em_ready}, 0);
         step();
         chk("stb_hold_mw_valid", {31'b0, mw_valid}, 0);
      end
      bus_ready = 1; #1;
      chk("stb_accept_ready", {31'b0, em_ready}, 1);
      step();
      drive(0, 0, 0, 2'd0, 0, 0, 0); bus_ready = 0;
      chk("stb_mw_valid", {31'b0, mw_valid}, 1);
      step();

      // signed halfword load, data returns two cycles after accept
      drive(1, 1, 0, 2'd1, 1, 32'h2002, 0); em_rd = 5'd9; bus_ready = 1; #1;
      chk("ldh_bv", {31'b0, bus_valid}, 1);
      chk("ldh_bus_write", {31'b0, bus_write}, 0);
      chk("ldh_be", {28'b0, bus_byte_en}, 32'hC);
      chk("ldh_ready", {31'b0, em_ready}, 1);
      step();
      drive(0, 0, 0, 2'd0, 0, 0, 0); bus_ready = 0;
      chk("ldh_mdv0_a", {31'b0, mw_mem_data_valid}, 0);
      chk("ldh_mw_valid0", {31'b0, mw_valid}, 0);
      chk("ldh_mw_rd", {27'b0, mw_rd}, 32'd9);
      chk("ldh_mw_regw", {31'b0, mw_reg_write}, 1);
      step();
      chk("ldh_mdv0_b", {31'b0, mw_mem_data_valid}, 0);
      chk("ldh_wait_bv", {31'b0, bus_valid}, 0);
      bus_rvalid = 1; bus_rdata = 32'h8001_0000;
      step();
      bus_rvalid = 0;
      chk("ldh_data", mw_reg_write_data, 32'hFFFF8001);
      chk("ldh_mdv1", {31'b0, mw_mem_data_valid}, 1);
      chk("ldh_mw_valid1", {31'b0, mw_valid}, 1);
      step();

      // unsigned byte load; a waiting entry is blocked until data returns
      drive(1, 1, 0, 2'd0, 0, 32'h2001, 0); bus_ready = 1;
      step();
      bus_ready = 0;
      drive(1, 0, 0, 2'd0, 0, 32'h4444, 32'h0); #1;
      chk("ldb_wait_ready", {31'b0, em_ready}, 0);
      chk("ldb_wait_bv", {31'b0, bus_valid}, 0);
      bus_rvalid = 1; bus_rdata = 32'h0000_F700;
      step();
      bus_rvalid = 0;
      chk("ldb_data", mw_reg_write_data, 32'h000000F7);
      chk("ldb_mdv", {31'b0, mw_mem_data_valid}, 1);
      chk("ldb_next_ready", {31'b0, em_ready}, 1);
      step();
      drive(0, 0, 0, 2'd0, 0, 0, 0);
      chk("ldb_next_data", mw_reg_write_data, 32'h4444);
      chk("ldb_next_valid", {31'b0, mw_valid}, 1);
      step();

      // reset during WAIT; a late rvalid must be dropped
      drive(1, 1, 0, 2'd2, 0, 32'h4000, 0); bus_ready = 1;
      step();
      drive(0, 0, 0, 2'd0, 0, 0, 0); bus_ready = 0; rest = 1;
      step();
      rest = 0;
      chk("rstw_mdv", {31'b0, mw_mem_data_valid}, 1);
      chk("rstw_mw_valid", {31'b0, mw_valid}, 0);
      bus_rvalid = 1; bus_rdata = 32'h12345678;
      step();
      bus_rvalid = 0;
      chk("rstw_late_valid", {31'b0, mw_valid}, 0);
      chk("rstw_late_data", mw_reg_write_data, 32'h0);
      drive(1, 0, 0, 2'd0, 0, 32'h55, 0); #1;
      chk("rstw_idle_ready", {31'b0, em_ready}, 1);
      step();
      drive(0, 0, 0, 2'd0, 0, 0, 0);
      chk("rstw_alu_data", mw_reg_write_data, 32'h55);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
